adc_cfg_arbiter: RTL and testbench

ADC_CFG_ARBITER -- requirements
Module: adc_cfg_arbiter

---
 rtl/adc_cfg_pkg.sv | 42 ++++
 rtl/adc_spi_shift.sv | 55 +++++
 rtl/adc_cfg_arbiter.sv | 148 ++++++++++++++
 tb/tb_adc_cfg_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_cfg_pkg.sv
// adc_cfg_pkg
// Shared constants, FSM state type and arbitration helper for the ADC
// serial configuration arbiter (adc_cfg_arbiter) and its serializer
// (adc_spi_shift).
package adc_cfg_pkg;

  localparam int CFG_WORD_W = 24;
  localparam int N_REQ      = 3;
  localparam int GAP_CYCLES = 2;

  localparam int IDX_W      = 2;
  localparam int BIT_CNT_W  = 5;
  localparam int GAP_CNT_W  = 2;

  localparam logic [15:0] PWDOWN_ADDR = 16'h0F02;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP
  } arb_state_e;

  // Returns the first requester with req set, searching upward from
  // 'start' and wrapping modulo N_REQ. The loop walks from the lowest
  // priority to the highest so the highest-priority hit is written last.
  function automatic logic [IDX_W-1:0] pick_winner(
    input logic [N_REQ-1:0] req_vec,
    input logic [IDX_W-1:0] start
  );
    logic [IDX_W-1:0] win;
    int idx;
    win = start;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req_vec[idx]) win = IDX_W'(idx);
    end
    return win;
  endfunction

endpackage

// File: rtl/adc_spi_shift.sv
// adc_spi_shift
// Serializer for one 24-bit ADC configuration frame. A one-cycle 'load'
// strobe captures the word; while 'shift_en' is high the word goes out
// MSB first with csb low, and 'last_bit' flags the final bit.
//
// Ports:
//   sclk      in   serial config clock, rising edge
//   rstb      in   asynchronous active-low reset
//   load      in   one-cycle strobe, captures word_in
//   shift_en  in   high for the 24 SHIFT cycles
//   word_in   in   24-bit word to capture ([23:8] address, [7:0] data)
//   latched   out  captured word, stable for the whole frame
//   last_bit  out  high during the cycle that sends bit 0
//   csb       out  ADC chip select, active-low
//   sdata     out  ADC serial data
module adc_spi_shift
  import adc_cfg_pkg::*;
(
  input  logic                  sclk,
  input  logic                  rstb,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic [CFG_WORD_W-1:0] word_in,
  output logic [CFG_WORD_W-1:0] latched,
  output logic                  last_bit,
  output logic                  csb,
  output logic                  sdata
);

  localparam logic [BIT_CNT_W-1:0] LAST_IDX = BIT_CNT_W'(CFG_WORD_W - 1);

  logic [BIT_CNT_W-1:0] bit_cnt;

  // The latched word is never shifted; the counter selects the outgoing
  // bit so the full word stays available for the power-down snoop.
  always_ff @(posedge sclk or negedge rstb) begin
    if (!rstb) begin
      latched <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      latched <= word_in;
      bit_cnt <= '0;
    end else if (shift_en) begin
      bit_cnt <= (bit_cnt == LAST_IDX) ? '0 : bit_cnt + BIT_CNT_W'(1);
    end
  end

  // csb and sdata decode straight from shift_en, which comes from the
  // asynchronously reset state register, so a reset mid-frame raises csb
  // without waiting for a clock edge.
  assign last_bit = shift_en && (bit_cnt == LAST_IDX);
  assign csb      = !shift_en;
  assign sdata    = shift_en & latched[LAST_IDX - bit_cnt];

endmodule

// File: rtl/adc_cfg_arbiter.sv
// adc_cfg_arbiter
// Arbitrates three configuration requesters (0 = init sequencer,
// 1 = deskew/pattern sequencer, 2 = external slow control) onto one ADC
// serial port. Each frame is LOAD (1 cycle), SHIFT (24 cycles) and
// GAP (2 cycles). done pulses in the first GAP cycle. A frame addressed
// to 16'h0F02 is mirrored into pwdown_ch.
//
// Build option:
//   ADC_CFG_ARB_RR_EN  defined: round-robin arbitration (the search starts
//                      one past the last winner). Undefined: fixed priority
//                      req[0] > req[1] > req[2], with no pointer register.
//
// Ports:
//   sclk       in   serial config clock, rising edge
//   rstb       in   asynchronous active-low reset
//   req        in   per-requester request, held until its done
//   word0..2   in   24-bit config word per requester
//   gnt        out  one-hot grant, LOAD through end of GAP
//   done       out  one-cycle completion pulse to the winner
//   busy       out  high whenever the FSM is not IDLE
//   csb        out  ADC chip select, active-low
//   sdata      out  ADC serial data, MSB first
//   pwdown_ch  out  data byte of the last frame sent to PWDOWN_ADDR
module adc_cfg_arbiter
  import adc_cfg_pkg::*;
(
  input  logic                  sclk,
  input  logic                  rstb,
  input  logic [N_REQ-1:0]      req,
  input  logic [CFG_WORD_W-1:0] word0,
  input  logic [CFG_WORD_W-1:0] word1,
  input  logic [CFG_WORD_W-1:0] word2,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      done,
  output logic                  busy,
  output logic                  csb,
  output logic                  sdata,
  output logic [7:0]            pwdown_ch
);

  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_CYCLES - 1);

  arb_state_e            state_q;
  arb_state_e            state_d;
  logic [GAP_CNT_W-1:0]  gap_cnt;
  logic [IDX_W-1:0]      search_start;
  logic [IDX_W-1:0]      winner;
  logic [CFG_WORD_W-1:0] sel_word;
  logic [CFG_WORD_W-1:0] latched;
  logic                  load;
  logic                  shift_en;
  logic                  last_bit;

`ifdef ADC_CFG_ARB_RR_EN
  logic [IDX_W-1:0] rr_ptr;

  // rr_ptr holds the requester searched first, i.e. one past the last winner.
  always_ff @(posedge sclk or negedge rstb) begin
    if (!rstb) begin
      rr_ptr <= '0;
    end else if (load) begin
      rr_ptr <= (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + IDX_W'(1);
    end
  end

  assign search_start = rr_ptr;
`else
  assign search_start = '0;
`endif

  assign winner = pick_winner(req, search_start);

  always_comb begin
    sel_word = word2;
    case (winner)
      IDX_W'(0): sel_word = word0;
      IDX_W'(1): sel_word = word1;
      default:   sel_word = word2;
    endcase
  end

  always_ff @(posedge sclk or negedge rstb) begin
    if (!rstb) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // The load strobe is raised in IDLE at the edge that leaves for LOAD,
  // so the serializer captures the word that is present at the grant.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_LOAD;
          load    = 1'b1;
        end
      end
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_d = ST_GAP;
      ST_GAP:   if (gap_cnt == GAP_LAST) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign shift_en = (state_q == ST_SHIFT);
  assign busy     = (state_q != ST_IDLE);

  // done and the power-down shadow update on the edge leaving SHIFT, so
  // both become visible in the first GAP cycle.
  always_ff @(posedge sclk or negedge rstb) begin
    if (!rstb) begin
      gnt       <= '0;
      done      <= '0;
      gap_cnt   <= '0;
      pwdown_ch <= 8'h00;
    end else begin
      done <= '0;

      if (load) begin
        gnt <= N_REQ'(1) << winner;
      end else if (state_q == ST_GAP && gap_cnt == GAP_LAST) begin
        gnt <= '0;
      end

      if (state_q == ST_GAP && gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + GAP_CNT_W'(1);
      else                                          gap_cnt <= '0;

      if (last_bit) begin
        done <= gnt;
        if (latched[CFG_WORD_W-1:8] == PWDOWN_ADDR) pwdown_ch <= latched[7:0];
      end
    end
  end

  adc_spi_shift u_shift (
    .sclk     (sclk),
    .rstb     (rstb),
    .load     (load),
    .shift_en (shift_en),
    .word_in  (sel_word),
    .latched  (latched),
    .last_bit (last_bit),
    .csb      (csb),
    .sdata    (sdata)
  );

endmodule

// File: tb/tb_adc_cfg_arbiter.sv
`timescale 1ns/1ps
module tb_adc_cfg_arbiter;

  logic        sclk = 1'b0;
  logic        rstb;
  logic [2:0]  req;
  logic [23:0] word0, word1, word2;
  logic [2:0]  gnt, done;
  logic        busy, csb, sdata;
  logic [7:0]  pwdown_ch;

  adc_cfg_arbiter dut (
    .sclk      (sclk),
    .rstb      (rstb),
    .req       (req),
    .word0     (word0),
    .word1     (word1),
    .word2     (word2),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .csb       (csb),
    .sdata     (sdata),
    .pwdown_ch (pwdown_ch)
  );

  // 20 MHz serial clock
  always #25 sclk = ~sclk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: a frame is a timeline counted from the IDLE sample
  // cycle N. Phase 0 = idle, 1 = LOAD, 2..25 = bits 23..0, 26..27 = GAP.
  int          m_phase = 0;
  int          m_win   = 0;
  int          m_ptr   = 0;
  logic [23:0] m_word  = '0;
  logic [7:0]  m_pw    = '0;

  // Observations used by the directed checks
  logic [23:0] cap_bits = '0;
  int          cap_n = 0;
  int          gnt_log[$];
  int          gnt_cyc_log[$];
  int          first_csb_cyc = -1;
  int          done_cyc = -1;
  int          busy_fall_cyc = -1;
  int          done_count = 0;
  logic [2:0]  done_val = '0;
  logic [7:0]  pw_at_done = '0;
  logic        prev_gnt_any = 1'b0;
  logic        prev_busy = 1'b0;
  logic        prev_csb = 1'b1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: wait expired at cycle %0d, got no event, expected one", name, cyc);
  endtask

  function automatic int model_pick(input logic [2:0] r, input int start);
    for (int k = 0; k < 3; k++) begin
      if (r[(start + k) % 3]) return (start + k) % 3;
    end
    return 0;
  endfunction

  // Per-cycle compare against the model, then the model consumes the
  // inputs that the DUT will sample at the next rising edge.
  always @(negedge sclk) begin : monitor
    logic [2:0] e_gnt, e_done;
    logic       e_csb, e_sdata, e_busy;
    int         start;
    cyc++;
    if (!rstb) begin
      m_phase = 0;
      m_pw    = '0;
      m_ptr   = 0;
    end else if (m_phase == 26 && m_word[23:8] == 16'h0F02) begin
      m_pw = m_word[7:0];
    end

    e_gnt   = (m_phase >= 1) ? 3'(1 << m_win) : 3'b000;
    e_done  = (m_phase == 26) ? 3'(1 << m_win) : 3'b000;
    e_busy  = (m_phase >= 1);
    e_csb   = !(m_phase >= 2 && m_phase <= 25);
    e_sdata = (m_phase >= 2 && m_phase <= 25) ? m_word[25 - m_phase] : 1'b0;

    checkOutput("gnt",       32'(gnt),       32'(e_gnt));
    checkOutput("done",      32'(done),      32'(e_done));
    checkOutput("busy",      32'(busy),      32'(e_busy));
    checkOutput("csb",       32'(csb),       32'(e_csb));
    checkOutput("sdata",     32'(sdata),     32'(e_sdata));
    checkOutput("pwdown_ch", 32'(pwdown_ch), 32'(m_pw));

    if (gnt != 0 && !prev_gnt_any) begin
      gnt_log.push_back(int'(gnt));
      gnt_cyc_log.push_back(cyc);
      cap_n    = 0;
      cap_bits = '0;
    end
    if (!csb) begin
      cap_bits = {cap_bits[22:0], sdata};
      cap_n++;
    end
    if (!csb && prev_csb) first_csb_cyc = cyc;
    if (!busy && prev_busy) busy_fall_cyc = cyc;
    if (done != 0) begin
      done_cyc   = cyc;
      done_val   = done;
      pw_at_done = pwdown_ch;
      done_count++;
    end
    prev_gnt_any = (gnt != 0);
    prev_busy    = busy;
    prev_csb     = csb;

    if (rstb) begin
      if (m_phase == 0) begin
        if (req != 0) begin
`ifdef ADC_CFG_ARB_RR_EN
          start = m_ptr;
`else
          start = 0;
`endif
          m_win   = model_pick(req, start);
          m_word  = (m_win == 0) ? word0 : (m_win == 1) ? word1 : word2;
          m_ptr   = (m_win + 1) % 3;
          m_phase = 1;
        end
      end else if (m_phase == 27) begin
        m_phase = 0;
      end else begin
        m_phase++;
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] r, input logic [23:0] w0,
                               input logic [23:0] w1, input logic [23:0] w2);
    @(posedge sclk);
    #1;
    req   = r;
    word0 = w0;
    word1 = w1;
    word2 = w2;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge sclk);
      #1;
      if (done != 0) seen = 1'b1;
    end
    if (!seen) timeoutFail(name);
  endtask

  task automatic wait_idle(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge sclk);
      #1;
      if (!busy) seen = 1'b1;
    end
    if (!seen) timeoutFail(name);
  endtask

  task automatic wait_grants(input int n, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge sclk);
      #1;
      if (gnt_log.size() >= n) seen = 1'b1;
    end
    if (!seen) timeoutFail(name);
  endtask

  // Hard stop in case something blocks outside the bounded waits
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at cycle %0d, expected to finish", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n0;
    int dc;
    int exp_order[5];
    int n_exp;
    bit seen;

    rstb  = 1'b0;
    req   = '0;
    word0 = '0;
    word1 = '0;
    word2 = '0;
    repeat (3) @(posedge sclk);
    #1;
    checkOutput("reset csb",    32'(csb),       32'd1);
    checkOutput("reset gnt",    32'(gnt),       32'd0);
    checkOutput("reset busy",   32'(busy),      32'd0);
    checkOutput("reset pwdown", 32'(pwdown_ch), 32'd0);
    @(posedge sclk);
    #1;
    rstb = 1'b1;
    repeat (2) @(posedge sclk);

    // Single request from requester 2
    $display("[TB] single request");
    gnt_log.delete();
    gnt_cyc_log.delete();
    applyStimulus(3'b100, 24'h0, 24'h0, 24'hA5C30F);
    n0 = cyc + 1;
    wait_done("single done");
    applyStimulus(3'b000, 24'h0, 24'h0, 24'h0);
    wait_idle("single idle");
    checkOutput("single gnt value", 32'(gnt_log.size() > 0 ? gnt_log[0] : 0), 32'd4);
    checkOutput("single gnt cycle", 32'(gnt_cyc_log.size() > 0 ? gnt_cyc_log[0] : 0), 32'(n0 + 1));
    checkOutput("single csb low cycle", 32'(first_csb_cyc), 32'(n0 + 2));
    checkOutput("single bits", 32'(cap_bits), 32'h00A5C30F);
    checkOutput("single bit count", 32'(cap_n), 32'd24);
    checkOutput("single done cycle", 32'(done_cyc), 32'(n0 + 26));
    checkOutput("single done value", 32'(done_val), 32'd4);
    checkOutput("single busy fall", 32'(busy_fall_cyc), 32'(n0 + 28));

    // Collision with all three requesters holding req
    $display("[TB] collision");
    gnt_log.delete();
    gnt_cyc_log.delete();
    applyStimulus(3'b111, 24'h111111, 24'h222222, 24'h333333);
`ifdef ADC_CFG_ARB_RR_EN
    exp_order = '{1, 2, 4, 1, 0};
    n_exp = 4;
    wait_grants(4, "rr grants");
    req = 3'b000;
`else
    exp_order = '{1, 1, 1, 2, 2};
    n_exp = 5;
    wait_grants(3, "fixed grants");
    req = 3'b110;
    wait_grants(5, "fixed grants after drop");
    req = 3'b000;
`endif
    wait_idle("collision idle");
    checkOutput("collision grant count", 32'(gnt_log.size()), 32'(n_exp));
    for (int i = 0; i < n_exp && i < gnt_log.size(); i++) begin
      checkOutput($sformatf("collision grant %0d", i), 32'(gnt_log[i]), 32'(exp_order[i]));
    end
    for (int i = 1; i < gnt_cyc_log.size(); i++) begin
      checkOutput($sformatf("collision spacing %0d", i),
                  32'(gnt_cyc_log[i] - gnt_cyc_log[i-1]), 32'd28);
    end

    // Power-down snoop
    $display("[TB] power-down snoop");
    applyStimulus(3'b010, 24'h0, 24'h0F023C, 24'h0);
    wait_done("pwdown done 1");
    applyStimulus(3'b000, 24'h0, 24'h0, 24'h0);
    wait_idle("pwdown idle 1");
    checkOutput("pwdown at done 1", 32'(pw_at_done), 32'h3C);
    checkOutput("pwdown done value", 32'(done_val), 32'd2);
    applyStimulus(3'b010, 24'h0, 24'h0F01FF, 24'h0);
    wait_done("pwdown done 2");
    applyStimulus(3'b000, 24'h0, 24'h0, 24'h0);
    wait_idle("pwdown idle 2");
    checkOutput("pwdown at done 2", 32'(pw_at_done), 32'h3C);
    checkOutput("pwdown held", 32'(pwdown_ch), 32'h3C);

    // Word change after grant
    $display("[TB] word change after grant");
    applyStimulus(3'b001, 24'h123456, 24'h0, 24'h0);
    repeat (5) @(posedge sclk);
    #1;
    word0 = 24'hFEDCBA;
    wait_done("word change done");
    applyStimulus(3'b000, 24'h0, 24'h0, 24'h0);
    wait_idle("word change idle");
    checkOutput("word change bits", 32'(cap_bits), 32'h00123456);
    checkOutput("word change done value", 32'(done_val), 32'd1);

    // Reset in the middle of SHIFT, request held across it
    $display("[TB] reset mid-frame");
    applyStimulus(3'b100, 24'h0, 24'h0, 24'hABCDEF);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge sclk);
      #1;
      if (!csb) seen = 1'b1;
    end
    if (!seen) timeoutFail("reset frame start");
    repeat (10) @(posedge sclk);
    #1;
    dc   = done_count;
    rstb = 1'b0;
    #1;
    checkOutput("abort csb",   32'(csb),   32'd1);
    checkOutput("abort gnt",   32'(gnt),   32'd0);
    checkOutput("abort busy",  32'(busy),  32'd0);
    checkOutput("abort sdata", 32'(sdata), 32'd0);
    repeat (3) @(posedge sclk);
    #1;
    rstb = 1'b1;
    checkOutput("abort no done", 32'(done_count), 32'(dc));
    wait_done("refresh done");
    applyStimulus(3'b000, 24'h0, 24'h0, 24'h0);
    wait_idle("refresh idle");
    checkOutput("refresh bits", 32'(cap_bits), 32'h00ABCDEF);
    checkOutput("refresh bit count", 32'(cap_n), 32'd24);
    checkOutput("refresh done count", 32'(done_count), 32'(dc + 1));
    checkOutput("refresh done value", 32'(done_val), 32'd4);

    // Randomized traffic, compared cycle by cycle against the model
    $display("[TB] random traffic");
    for (int i = 0; i < 2500; i++) begin
      @(posedge sclk);
      #1;
      if ($urandom_range(0, 7) == 0) req = 3'($urandom_range(0, 7));
      word0 = 24'($urandom);
      word1 = ($urandom_range(0, 1) == 1) ? {16'h0F02, 8'($urandom)} : 24'($urandom);
      word2 = 24'($urandom);
    end
    req = 3'b000;
    wait_idle("random idle");
    repeat (2) @(posedge sclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
